// File: rtl/countdown_timer_clock_pkg.sv
// Shared state encodings, BCD limits and BCD/binary helpers for the countdown clock.
// Pure package: no logic, no latency, no flow control.
package countdown_timer_clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_units;
      logic [3:0] sec_tens;
      logic [3:0] sec_units;
   } bcd_time_t;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

   function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
      return ({3'b000, tens} * 7'd10) + {3'b000, units};
   endfunction

   // Repeated subtraction keeps the conversion free of a divider for values up to 99.
   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      logic [3:0] t;
      logic [6:0] r;
      t = 4'd0;
      r = v;
      for (int i = 0; i < 9; i++) begin
         if (r >= 7'd10) begin
            r = r - 7'd10;
            t = t + 4'd1;
         end
      end
      return {t, 4'(r)};
   endfunction

endpackage

// File: rtl/countdown_timer_clock_digit.sv
// One BCD down-counting digit: load or decrement with wrap to WRAP and borrow-out.
// Registered value, 1-cycle latency; borrow is combinational; no backpressure.
module bcd_down_digit
   import countdown_timer_clock_pkg::*;
#(
   parameter logic [3:0] WRAP = BCD_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] value,
   output logic       borrow
);

   assign borrow = dec && (value == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= 4'd0;
      end else if (load) begin
         value <= load_val;
      end else if (dec) begin
         value <= (value == 4'd0) ? WRAP : value - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer_clock.sv
// Per-player MM:SS BCD countdown clock with Fischer increment and sticky timeout.
// All outputs registered, 1-cycle latency; no backpressure (strobes always accepted).
module countdown_timer_clock
   import countdown_timer_clock_pkg::*;
#(
   parameter int INC_SEC = 0,
   parameter int MAX_MIN = 99
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       CE,
   input  logic       IMPULSE,
   input  logic       LOAD,
   input  logic       ADD_INC,
   input  logic [3:0] pre_min_tens,
   input  logic [3:0] pre_min_units,
   input  logic [3:0] pre_sec_tens,
   input  logic [3:0] pre_sec_units,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       RUNNING,
   output logic       TIMEOUT
);

   localparam logic [6:0] INC_BIN = 7'(INC_SEC);
   localparam logic [6:0] MAX_BIN = 7'(MAX_MIN);

   state_t     state_q, state_d;
   logic       timeout_q, timeout_d;
   logic       dig_load, tick, expire;
   logic       b_su, b_st, b_mu, b_mt;
   logic [3:0] v_mt, v_mu, v_st, v_su;
   bcd_time_t  cur, preset, inc_val, load_val, sat_val;
   logic [6:0] sec_sum, min_sum;
   logic [7:0] sat_min_bcd, sec_bcd, min_bcd;

   assign cur         = '{min_tens: v_mt, min_units: v_mu, sec_tens: v_st, sec_units: v_su};
   assign sat_min_bcd = bin2bcd(MAX_BIN);
   assign sat_val     = '{min_tens: sat_min_bcd[7:4], min_units: sat_min_bcd[3:0],
                          sec_tens: SEC_TENS_MAX, sec_units: BCD_MAX};

   always_comb begin
      preset.min_tens  = clamp_digit(pre_min_tens, BCD_MAX);
      preset.min_units = clamp_digit(pre_min_units, BCD_MAX);
      preset.sec_tens  = clamp_digit(pre_sec_tens, SEC_TENS_MAX);
      preset.sec_units = clamp_digit(pre_sec_units, BCD_MAX);
      if (bcd2bin(preset.min_tens, preset.min_units) > MAX_BIN) begin
         preset = sat_val;
      end
   end

   // Seconds carry into minutes; minutes beyond the ceiling pin the whole value to MAX:59.
   always_comb begin
      sec_sum = bcd2bin(cur.sec_tens, cur.sec_units) + INC_BIN;
      min_sum = bcd2bin(cur.min_tens, cur.min_units);
      if (sec_sum >= 7'd60) begin
         sec_sum = sec_sum - 7'd60;
         min_sum = min_sum + 7'd1;
      end
      sec_bcd = bin2bcd(sec_sum);
      min_bcd = bin2bcd(min_sum);
      if (min_sum > MAX_BIN) begin
         inc_val = sat_val;
      end else begin
         inc_val = '{min_tens: min_bcd[7:4], min_units: min_bcd[3:0],
                     sec_tens: sec_bcd[7:4], sec_units: sec_bcd[3:0]};
      end
   end

   // A tick at 00:01 lands on 00:00; a borrow out of the top digit would mean underflow.
   assign expire = tick && ((cur == 16'h0001) || b_mt);

   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      dig_load  = 1'b0;
      load_val  = preset;
      tick      = 1'b0;
      if (LOAD) begin
         dig_load  = 1'b1;
         state_d   = ST_IDLE;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ADD_INC) begin
                  dig_load = 1'b1;
                  load_val = inc_val;
               end
               if (CE && (cur != 16'h0000)) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (ADD_INC) begin
                  dig_load = 1'b1;
                  load_val = inc_val;
               end else if (CE && IMPULSE) begin
                  tick = 1'b1;
               end
               if (!CE) begin
                  state_d = ST_IDLE;
               end else if (expire) begin
                  state_d   = ST_EXPIRED;
                  timeout_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q   <= ST_IDLE;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_units (
      .clk(CLK), .rst_n(CLR), .load(dig_load), .load_val(load_val.sec_units),
      .dec(tick), .value(v_su), .borrow(b_su)
   );

   bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
      .clk(CLK), .rst_n(CLR), .load(dig_load), .load_val(load_val.sec_tens),
      .dec(b_su), .value(v_st), .borrow(b_st)
   );

   bcd_down_digit #(.WRAP(BCD_MAX)) u_min_units (
      .clk(CLK), .rst_n(CLR), .load(dig_load), .load_val(load_val.min_units),
      .dec(b_st), .value(v_mu), .borrow(b_mu)
   );

   bcd_down_digit #(.WRAP(BCD_MAX)) u_min_tens (
      .clk(CLK), .rst_n(CLR), .load(dig_load), .load_val(load_val.min_tens),
      .dec(b_mu), .value(v_mt), .borrow(b_mt)
   );

   assign min_tens  = v_mt;
   assign min_units = v_mu;
   assign sec_tens  = v_st;
   assign sec_units = v_su;
   assign RUNNING   = (state_q == ST_RUN);
   assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_countdown_timer_clock.sv
// Directed bench for countdown_timer_clock with INC_SEC=5, MAX_MIN=99.
// Observed word is {RUNNING, TIMEOUT, MM:SS as four BCD nibbles}.
module tb_countdown_timer_clock;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       ce = 1'b0, impulse = 1'b0, load = 1'b0, add_inc = 1'b0;
   logic [3:0] p_mt = 4'd0, p_mu = 4'd0, p_st = 4'd0, p_su = 4'd0;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       running, timeout;
   int         checks = 0;
   int         errors = 0;

   countdown_timer_clock #(.INC_SEC(5), .MAX_MIN(99)) dut (
      .CLK(clk), .CLR(clr), .CE(ce), .IMPULSE(impulse), .LOAD(load), .ADD_INC(add_inc),
      .pre_min_tens(p_mt), .pre_min_units(p_mu), .pre_sec_tens(p_st), .pre_sec_units(p_su),
      .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
      .RUNNING(running), .TIMEOUT(timeout)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic ld, input logic ad, input logic im);
      load = ld; add_inc = ad; impulse = im;
      @(posedge clk);
      #1;
      load = 1'b0; add_inc = 1'b0; impulse = 1'b0;
   endtask

   task automatic set_preset(input logic [15:0] p);
      p_mt = p[15:12]; p_mu = p[11:8]; p_st = p[7:4]; p_su = p[3:0];
   endtask

   task automatic chk(input string tag, input logic r, input logic t, input logic [15:0] v);
      logic [17:0] obs, exp;
      obs = {running, timeout, min_tens, min_units, sec_tens, sec_units};
      exp = {r, t, v};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #12;
      chk("reset", 1'b0, 1'b0, 16'h0000);
      clr = 1'b1;

      // 1: count 00:03 down to expiry
      set_preset(16'h0003); cyc(1, 0, 0); chk("t1_load", 0, 0, 16'h0003);
      ce = 1'b1;            cyc(0, 0, 0); chk("t1_run", 1, 0, 16'h0003);
      cyc(0, 0, 1); chk("t1_tick1", 1, 0, 16'h0002);
      cyc(0, 0, 1); chk("t1_tick2", 1, 0, 16'h0001);
      cyc(0, 0, 1); chk("t1_expire", 0, 1, 16'h0000);
      cyc(0, 0, 1); chk("t1_frozen_imp", 0, 1, 16'h0000);
      cyc(0, 1, 0); chk("t1_frozen_inc", 0, 1, 16'h0000);

      // 2: multi-digit borrow, then pause
      ce = 1'b0; set_preset(16'h1000); cyc(1, 0, 0); chk("t2_load", 0, 0, 16'h1000);
      ce = 1'b1; cyc(0, 0, 0); chk("t2_run", 1, 0, 16'h1000);
      cyc(0, 0, 1); chk("t2_borrow", 1, 0, 16'h0959);
      ce = 1'b0; cyc(0, 0, 1); chk("t2_pause", 0, 0, 16'h0959);
      cyc(0, 0, 1); chk("t2_idle_imp", 0, 0, 16'h0959);

      // 3: increment with carry and saturation
      set_preset(16'h0057); cyc(1, 0, 0); chk("t3_load", 0, 0, 16'h0057);
      ce = 1'b1; cyc(0, 0, 0); chk("t3_run", 1, 0, 16'h0057);
      cyc(0, 1, 0); chk("t3_inc_carry", 1, 0, 16'h0102);
      ce = 1'b0; cyc(0, 0, 0); chk("t3_stop", 0, 0, 16'h0102);
      set_preset(16'h9958); cyc(1, 0, 0); chk("t3_load_hi", 0, 0, 16'h9958);
      cyc(0, 1, 0); chk("t3_saturate", 0, 0, 16'h9959);
      cyc(0, 1, 0); chk("t3_saturate2", 0, 0, 16'h9959);

      // 4: strobe priority
      ce = 1'b1; cyc(0, 0, 0); chk("t4_run", 1, 0, 16'h9959);
      set_preset(16'h1234); cyc(1, 1, 1); chk("t4_load_wins", 0, 0, 16'h1234);
      cyc(0, 0, 0); chk("t4_rerun", 1, 0, 16'h1234);
      ce = 1'b0; set_preset(16'h0030); cyc(1, 0, 0); chk("t4_load30", 0, 0, 16'h0030);
      ce = 1'b1; cyc(0, 0, 0); chk("t4_run30", 1, 0, 16'h0030);
      cyc(0, 1, 1); chk("t4_inc_over_tick", 1, 0, 16'h0035);
      cyc(0, 0, 1); chk("t4_tick", 1, 0, 16'h0034);

      // 5: preset sanitising and zero preset
      ce = 1'b0; set_preset(16'hA079); cyc(1, 0, 0); chk("t5_clamp", 0, 0, 16'h9059);
      set_preset(16'h0000); cyc(1, 0, 0); chk("t5_zero_load", 0, 0, 16'h0000);
      ce = 1'b1; cyc(0, 0, 0); chk("t5_zero_ce", 0, 0, 16'h0000);
      cyc(0, 0, 1); chk("t5_zero_imp", 0, 0, 16'h0000);

      // 6: asynchronous clear between edges
      ce = 1'b0; set_preset(16'h0500); cyc(1, 0, 0);
      ce = 1'b1; cyc(0, 0, 0); chk("t6_run", 1, 0, 16'h0500);
      #2; clr = 1'b0; #1;
      chk("t6_async_clr", 0, 0, 16'h0000);
      #2; clr = 1'b1;
      @(posedge clk); #1;
      cyc(0, 0, 1); chk("t6_post_imp", 0, 0, 16'h0000);
      cyc(0, 0, 1); chk("t6_post_imp2", 0, 0, 16'h0000);
      set_preset(16'h0002); cyc(1, 0, 0); chk("t6_reload", 0, 0, 16'h0002);
      cyc(0, 0, 0); chk("t6_rerun", 1, 0, 16'h0002);
      cyc(0, 0, 1); chk("t6_tick", 1, 0, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
